epochtv1_vram_arb: RTL and testbench

- Arbitrates the two external 2 KB VRAM banks (A/B, 11-bit address each) between two requesters:
  - CPU bus port (reads/writes at $2000-$2FFF);
  - epochtv1 render fetch engine.
- One access slot per CE period (CE = 1-in-7 CLK pixel enable).
- Render has fixed priority, with optional CPU anti-starvation.
- Sits between the epochtv1 core and the VA/VD/nVWE/nVCS pins.

---
 rtl/scv_pkg.sv | 20 ++
 rtl/epochtv1_vram_arb_if.sv | 32 +++
 rtl/epochtv1_vram_arb.sv | 121 ++++++++++++
 tb/tb_epochtv1_vram_arb.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scv_pkg.sv
// Shared types for the epochtv1 VRAM arbiter: address format, arbiter states, bank select helper.
package scv_pkg;

    localparam int VRAM_BANK_BIT = 11;

    typedef logic [11:0] vram_addr_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REN    = 2'd1,
        CPU_RD = 2'd2,
        CPU_WR = 2'd3
    } vram_arb_state_t;

    // Active-low chip selects: only the addressed bank is enabled.
    function automatic logic [1:0] bank_cs_n(input vram_addr_t a);
        return ~(2'b01 << a[VRAM_BANK_BIT]);
    endfunction

endpackage

// File: rtl/epochtv1_vram_arb_if.sv
// Requester, VRAM pin and debug bundle of the epochtv1 VRAM arbiter.
// Handshake: CPU_REQ is a level held until the one-CLK CPU_ACK; REN_REQ is sampled on CE only.
interface epochtv1_vram_arb_if;

    logic                    CPU_REQ;
    logic                    CPU_WE;
    scv_pkg::vram_addr_t     CPU_A;
    logic [7:0]              CPU_DI;
    logic [7:0]              CPU_DO;
    logic                    CPU_ACK;
    logic                    REN_REQ;
    scv_pkg::vram_addr_t     REN_A;
    logic [7:0]              REN_DO;
    logic                    REN_VALID;
    logic [10:0]             VA;
    logic [7:0]              VD_I;
    logic [7:0]              VD_O;
    logic                    nVWE;
    logic [1:0]              nVCS;
    scv_pkg::vram_arb_state_t dbg_state;

    modport slave (
        input  CPU_REQ, CPU_WE, CPU_A, CPU_DI, REN_REQ, REN_A, VD_I,
        output CPU_DO, CPU_ACK, REN_DO, REN_VALID, VA, VD_O, nVWE, nVCS, dbg_state
    );

    modport master (
        output CPU_REQ, CPU_WE, CPU_A, CPU_DI, REN_REQ, REN_A, VD_I,
        input  CPU_DO, CPU_ACK, REN_DO, REN_VALID, VA, VD_O, nVWE, nVCS, dbg_state
    );

endinterface

// File: rtl/epochtv1_vram_arb.sv
// One-slot-per-CE VRAM arbiter: render has fixed priority over the CPU port.
// Optional CPU anti-starvation counter enabled by macro EPOCHTV1_VRAM_ANTISTARVE_EN.
module epochtv1_vram_arb
    import scv_pkg::*;
`ifdef EPOCHTV1_VRAM_ANTISTARVE_EN
    #(parameter int STARVE_MAX = 4)
`endif
(
    input  logic                CLK,
    input  logic                RES,
    input  logic                CE,
    epochtv1_vram_arb_if.slave  bus
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_REN    = REN;
    localparam logic [1:0] ST_CPU_RD = CPU_RD;
    localparam logic [1:0] ST_CPU_WR = CPU_WR;

    logic [1:0]  r_state;
    logic [10:0] r_va;
    logic [7:0]  r_vd_o;
    logic        r_nvwe;
    logic [1:0]  r_nvcs;
    logic [7:0]  r_cpu_do;
    logic        r_cpu_ack;
    logic [7:0]  r_ren_do;
    logic        r_ren_valid;

    logic w_cpu_pend;
    logic w_force;
    logic w_grant_ren;
    logic w_grant_cpu;

    // The request being completed this CE is still high; it must not win a second slot.
    assign w_cpu_pend  = bus.CPU_REQ && (r_state != ST_CPU_RD) && (r_state != ST_CPU_WR);
    assign w_grant_ren = bus.REN_REQ && !w_force;
    assign w_grant_cpu = w_cpu_pend && !w_grant_ren;

`ifdef EPOCHTV1_VRAM_ANTISTARVE_EN
    logic [2:0] r_starve;

    assign w_force = w_cpu_pend && (r_starve == 3'(STARVE_MAX));

    always_ff @(posedge CLK) begin
        if (RES) begin
            r_starve <= '0;
        end else if (CE) begin
            if (w_grant_cpu || !w_cpu_pend)
                r_starve <= '0;
            else if (w_grant_ren)
                r_starve <= r_starve + 3'd1;
        end
    end
`else
    assign w_force = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RES) begin
            r_state     <= ST_IDLE;
            r_va        <= '0;
            r_vd_o      <= '0;
            r_nvwe      <= 1'b1;
            r_nvcs      <= 2'b11;
            r_cpu_do    <= '0;
            r_cpu_ack   <= 1'b0;
            r_ren_do    <= '0;
            r_ren_valid <= 1'b0;
        end else begin
            r_cpu_ack   <= 1'b0;
            r_ren_valid <= 1'b0;
            if (CE) begin
                case (r_state)
                    ST_REN: begin
                        r_ren_do    <= bus.VD_I;
                        r_ren_valid <= 1'b1;
                    end
                    ST_CPU_RD: begin
                        r_cpu_do  <= bus.VD_I;
                        r_cpu_ack <= 1'b1;
                    end
                    ST_CPU_WR: r_cpu_ack <= 1'b1;
                    default: ;
                endcase

                // Address, data and direction are latched here and held for the whole slot.
                if (w_grant_ren) begin
                    r_state <= ST_REN;
                    r_va    <= bus.REN_A[10:0];
                    r_nvcs  <= bank_cs_n(bus.REN_A);
                    r_nvwe  <= 1'b1;
                    r_vd_o  <= '0;
                end else if (w_grant_cpu) begin
                    r_state <= bus.CPU_WE ? ST_CPU_WR : ST_CPU_RD;
                    r_va    <= bus.CPU_A[10:0];
                    r_nvcs  <= bank_cs_n(bus.CPU_A);
                    r_nvwe  <= !bus.CPU_WE;
                    r_vd_o  <= bus.CPU_WE ? bus.CPU_DI : 8'h00;
                end else begin
                    r_state <= ST_IDLE;
                    r_va    <= '0;
                    r_nvcs  <= 2'b11;
                    r_nvwe  <= 1'b1;
                    r_vd_o  <= '0;
                end
            end
        end
    end

    assign bus.VA        = r_va;
    assign bus.VD_O      = r_vd_o;
    assign bus.nVWE      = r_nvwe;
    assign bus.nVCS      = r_nvcs;
    assign bus.CPU_DO    = r_cpu_do;
    assign bus.CPU_ACK   = r_cpu_ack;
    assign bus.REN_DO    = r_ren_do;
    assign bus.REN_VALID = r_ren_valid;
    assign bus.dbg_state = vram_arb_state_t'(r_state);

endmodule

// File: tb/tb_epochtv1_vram_arb.sv
// Self-checking bench for epochtv1_vram_arb: directed scenarios plus a randomized slot-level model.
module tb_epochtv1_vram_arb;
    import scv_pkg::*;

    logic       CLK = 1'b0;
    logic       RES = 1'b1;
    logic       CE;
    int         ce_cnt = 0;
    int         n_cmp = 0;
    int         n_fail = 0;

    logic [7:0] vram [0:4095];
    logic [7:0] mem_ref [0:4095];
    logic [7:0] exp_q [$];
    logic       ld_en = 1'b0;
    logic [11:0] ld_a = '0;
    logic [7:0] ld_d = '0;

    epochtv1_vram_arb_if bus();

    epochtv1_vram_arb dut (
        .CLK (CLK),
        .RES (RES),
        .CE  (CE),
        .bus (bus)
    );

    // clock / CE
    always #5 CLK = ~CLK;
    always @(posedge CLK) ce_cnt <= (ce_cnt == 6) ? 0 : ce_cnt + 1;
    assign CE = (ce_cnt == 6);

    // external VRAM: two 2 KB banks, stored as {bank, offset}
    assign bus.VD_I = !bus.nVCS[0] ? vram[{1'b0, bus.VA}] :
                      !bus.nVCS[1] ? vram[{1'b1, bus.VA}] : 8'h00;
    always @(posedge CLK) begin
        if (ld_en) vram[ld_a] <= ld_d;
        else if (!bus.nVWE) begin
            if (!bus.nVCS[0]) vram[{1'b0, bus.VA}] <= bus.VD_O;
            if (!bus.nVCS[1]) vram[{1'b1, bus.VA}] <= bus.VD_O;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic wait_ce_edge();
        @(negedge CLK);
        while (!CE) @(negedge CLK);
        @(posedge CLK);
        #1;
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_a = a; ld_d = d;
        @(posedge CLK); #1;
        ld_en = 1'b0;
    endtask

    task automatic cpu_access(input logic we, input logic [11:0] a, input logic [7:0] di,
                              output int lat, output logic [7:0] rd);
        bus.CPU_WE = we; bus.CPU_A = a; bus.CPU_DI = di; bus.CPU_REQ = 1'b1;
        wait_ce_edge();
        lat = 0; rd = 8'h00;
        for (int i = 1; i <= 40; i++) begin
            @(posedge CLK); #1;
            if (bus.CPU_ACK) begin lat = i; rd = bus.CPU_DO; break; end
        end
        bus.CPU_REQ = 1'b0;
    endtask

    task automatic test_reset();
        bus.CPU_REQ = 0; bus.CPU_WE = 0; bus.CPU_A = '0; bus.CPU_DI = '0;
        bus.REN_REQ = 0; bus.REN_A = '0;
        RES = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            ld_en = 1'b1; ld_a = 12'(i); ld_d = 8'($urandom);
            @(posedge CLK); #1;
        end
        ld_en = 1'b0;
        n_cmp++; if (bus.VA !== 11'h000) begin n_fail++; $display("FAIL reset_va: got %h expected 000", bus.VA); end
        n_cmp++; if (bus.VD_O !== 8'h00) begin n_fail++; $display("FAIL reset_vd_o: got %h expected 00", bus.VD_O); end
        n_cmp++; if (bus.nVWE !== 1'b1) begin n_fail++; $display("FAIL reset_nvwe: got %b expected 1", bus.nVWE); end
        n_cmp++; if (bus.nVCS !== 2'b11) begin n_fail++; $display("FAIL reset_nvcs: got %b expected 11", bus.nVCS); end
        n_cmp++; if (bus.CPU_DO !== 8'h00) begin n_fail++; $display("FAIL reset_cpu_do: got %h expected 00", bus.CPU_DO); end
        n_cmp++; if (bus.CPU_ACK !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ack: got %b expected 0", bus.CPU_ACK); end
        n_cmp++; if (bus.REN_DO !== 8'h00) begin n_fail++; $display("FAIL reset_ren_do: got %h expected 00", bus.REN_DO); end
        n_cmp++; if (bus.REN_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_ren_valid: got %b expected 0", bus.REN_VALID); end
        n_cmp++; if (bus.dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected IDLE", bus.dbg_state); end
        RES = 1'b0;
    endtask

    task automatic test_read();
        int lat; int bad; logic [7:0] rd;
        poke(12'h123, 8'h5A);
        bus.CPU_WE = 0; bus.CPU_A = 12'h123; bus.CPU_REQ = 1;
        wait_ce_edge();
        n_cmp++; if ({bus.nVCS, bus.VA, bus.nVWE} !== {2'b10, 11'h123, 1'b1})
            begin n_fail++; $display("FAIL read_pins: got cs=%b va=%h we_n=%b expected cs=10 va=123 we_n=1", bus.nVCS, bus.VA, bus.nVWE); end
        lat = 0; bad = 0; rd = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge CLK); #1;
            if (bus.CPU_ACK) begin lat = i; rd = bus.CPU_DO; break; end
            if (bus.nVCS !== 2'b10 || bus.VA !== 11'h123) bad++;
        end
        bus.CPU_REQ = 0;
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL read_slot_hold: got %0d bad clocks expected 0", bad); end
        n_cmp++; if (lat !== 7) begin n_fail++; $display("FAIL read_latency: got %0d expected 7", lat); end
        n_cmp++; if (rd !== 8'h5A) begin n_fail++; $display("FAIL read_data: got %h expected 5a", rd); end
    endtask

    task automatic test_write();
        int low; int acks;
        bus.CPU_WE = 1; bus.CPU_A = 12'h8FF; bus.CPU_DI = 8'hC3; bus.CPU_REQ = 1;
        wait_ce_edge();
        low = 0; acks = 0;
        for (int i = 0; i <= 30; i++) begin
            if (i > 0) begin @(posedge CLK); #1; end
            if (bus.CPU_ACK) begin acks++; bus.CPU_REQ = 0; break; end
            if (bus.nVWE === 1'b0 && bus.nVCS === 2'b01 && bus.VD_O === 8'hC3) low++;
        end
        repeat (14) begin @(posedge CLK); #1; if (bus.CPU_ACK) acks++; end
        n_cmp++; if (low !== 7) begin n_fail++; $display("FAIL write_strobe: got %0d clocks expected 7", low); end
        n_cmp++; if (vram[12'h8FF] !== 8'hC3) begin n_fail++; $display("FAIL write_data: got %h expected c3", vram[12'h8FF]); end
        n_cmp++; if (acks !== 1) begin n_fail++; $display("FAIL write_ack_count: got %0d expected 1", acks); end
    endtask

    task automatic test_contention();
        int ren_t; int ack_t; logic [7:0] ren_d; logic [7:0] ack_d; logic [10:0] va7;
        poke(12'h010, 8'hE1);
        poke(12'h200, 8'h4B);
        bus.REN_REQ = 1; bus.REN_A = 12'h010;
        bus.CPU_WE = 0; bus.CPU_A = 12'h200; bus.CPU_REQ = 1;
        wait_ce_edge();
        n_cmp++; if (bus.VA !== 11'h010) begin n_fail++; $display("FAIL cont_render_first: got va=%h expected 010", bus.VA); end
        bus.REN_REQ = 0;
        ren_t = 0; ack_t = 0; ren_d = 0; ack_d = 0; va7 = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge CLK); #1;
            if (i == 7) va7 = bus.VA;
            if (bus.REN_VALID) begin ren_t = i; ren_d = bus.REN_DO; end
            if (bus.CPU_ACK) begin ack_t = i; ack_d = bus.CPU_DO; break; end
        end
        bus.CPU_REQ = 0;
        n_cmp++; if (ren_t !== 7 || ren_d !== 8'hE1) begin n_fail++; $display("FAIL cont_render: got t=%0d d=%h expected t=7 d=e1", ren_t, ren_d); end
        n_cmp++; if (va7 !== 11'h200) begin n_fail++; $display("FAIL cont_cpu_va: got %h expected 200", va7); end
        n_cmp++; if (ack_t !== 14 || ack_d !== 8'h4B) begin n_fail++; $display("FAIL cont_cpu_ack: got t=%0d d=%h expected t=14 d=4b", ack_t, ack_d); end
    endtask

    task automatic test_starve();
        int ack_slot;
        bus.CPU_WE = 0; bus.CPU_A = 12'h444; bus.CPU_REQ = 1;
        bus.REN_REQ = 1;
        ack_slot = 0;
        for (int c = 1; c <= 21; c++) begin
            bus.REN_A = 12'($urandom);
            wait_ce_edge();
            if (bus.CPU_ACK) begin ack_slot = c; break; end
        end
        bus.CPU_REQ = 0; bus.REN_REQ = 0;
`ifdef EPOCHTV1_VRAM_ANTISTARVE_EN
        n_cmp++; if (ack_slot !== 6) begin n_fail++; $display("FAIL starve_forced_grant: got ack at CE %0d expected 6", ack_slot); end
`else
        n_cmp++; if (ack_slot !== 0) begin n_fail++; $display("FAIL starve_strict: got ack at CE %0d expected none", ack_slot); end
`endif
        wait_ce_edge(); wait_ce_edge();
    endtask

    task automatic test_reset_mid();
        int acks; int lat; logic [7:0] rd;
        poke(12'h9AA, 8'h3C);
        bus.CPU_WE = 1; bus.CPU_A = 12'h055; bus.CPU_DI = 8'h77; bus.CPU_REQ = 1;
        wait_ce_edge();
        n_cmp++; if (bus.nVWE !== 1'b0) begin n_fail++; $display("FAIL rstmid_wr_active: got %b expected 0", bus.nVWE); end
        repeat (3) begin @(posedge CLK); #1; end
        RES = 1;
        @(posedge CLK); #1;
        n_cmp++; if ({bus.nVWE, bus.nVCS, bus.CPU_ACK} !== 4'b1110)
            begin n_fail++; $display("FAIL rstmid_pins: got we_n=%b cs=%b ack=%b expected 1 11 0", bus.nVWE, bus.nVCS, bus.CPU_ACK); end
        RES = 0; bus.CPU_REQ = 0;
        acks = 0;
        repeat (14) begin @(posedge CLK); #1; if (bus.CPU_ACK) acks++; end
        n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL rstmid_no_ack: got %0d expected 0", acks); end
        cpu_access(1'b0, 12'h9AA, 8'h00, lat, rd);
        n_cmp++; if (lat !== 7 || rd !== 8'h3C) begin n_fail++; $display("FAIL rstmid_next: got lat=%0d d=%h expected 7 3c", lat, rd); end
    endtask

    task automatic test_abandon();
        int acks; int bad;
        bus.CPU_WE = 0; bus.CPU_A = 12'h7AB; bus.CPU_REQ = 1;
        bus.REN_REQ = 1;
        acks = 0; bad = 0;
        for (int c = 0; c < 6; c++) begin
            bus.REN_A = 12'($urandom_range(0, 12'h6FF));
            if (c == 2) bus.CPU_REQ = 0;
            for (int k = 0; k < 7; k++) begin
                @(posedge CLK); #1;
                if (bus.CPU_ACK) acks++;
                if (bus.VA === 11'h7AB) bad++;
            end
        end
        bus.REN_REQ = 0;
        wait_ce_edge(); wait_ce_edge();
        n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL abandon_ack: got %0d expected 0", acks); end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL abandon_va: got %0d cpu-address clocks expected 0", bad); end
    endtask

    // Slot-level reference: each CE retires the previous slot then picks a winner by priority rules.
    task automatic test_random();
        int slot_kind; int starve; bit cpu_req; bit ren_req; bit pend; bit force_cpu;
        logic [11:0] s_a; logic s_we; logic [7:0] s_di;
        logic [11:0] req_a; logic req_we; logic [7:0] req_di; logic [11:0] ren_a;
        logic [10:0] e_va; logic [1:0] e_cs; logic e_we_n; logic [7:0] exp_d;
        int bad_pins; int bad_pulse;
        for (int i = 0; i < 4096; i++) mem_ref[i] = vram[i];
        exp_q.delete();
        slot_kind = 0; starve = 0; cpu_req = 0; ren_req = 0;
        s_a = 0; s_we = 0; s_di = 0; req_a = 0; req_we = 0; req_di = 0; ren_a = 0;
        e_va = 0; e_cs = 2'b11; e_we_n = 1;
        bad_pins = 0; bad_pulse = 0;
        bus.CPU_REQ = 0; bus.REN_REQ = 0;
        wait_ce_edge();
        for (int s = 0; s < 300; s++) begin
            if (!cpu_req && $urandom_range(0, 9) < 4) begin
                cpu_req = 1; req_we = 1'($urandom_range(0, 1)); req_a = 12'($urandom); req_di = 8'($urandom);
                bus.CPU_WE = req_we; bus.CPU_A = req_a; bus.CPU_DI = req_di;
            end else if (cpu_req && slot_kind != 2 && $urandom_range(0, 19) == 0) begin
                cpu_req = 0;
            end else if (slot_kind == 2) begin
                bus.CPU_WE = 1'($urandom_range(0, 1)); bus.CPU_A = 12'($urandom); bus.CPU_DI = 8'($urandom);
            end
            ren_req = ($urandom_range(0, 9) < 5); ren_a = 12'($urandom); bus.REN_A = ren_a;
            bus.CPU_REQ = cpu_req; bus.REN_REQ = ren_req;
            for (int k = 1; k <= 6; k++) begin
                @(posedge CLK); #1;
                if (k == 2) begin bus.REN_REQ = !ren_req; bus.CPU_REQ = !cpu_req; end
                if (k == 4) begin bus.REN_REQ = ren_req; bus.CPU_REQ = cpu_req; end
                if (bus.CPU_ACK !== 1'b0 || bus.REN_VALID !== 1'b0) bad_pulse++;
                if (bus.VA !== e_va || bus.nVCS !== e_cs || bus.nVWE !== e_we_n) bad_pins++;
                if (slot_kind == 2 && s_we && bus.VD_O !== s_di) bad_pins++;
            end
            @(posedge CLK); #1;
            // retire previous slot
            n_cmp++; if (bus.REN_VALID !== (slot_kind == 1)) begin n_fail++; $display("FAIL rnd_valid slot %0d: got %b expected %b", s, bus.REN_VALID, slot_kind == 1); end
            n_cmp++; if (bus.CPU_ACK !== (slot_kind == 2)) begin n_fail++; $display("FAIL rnd_ack slot %0d: got %b expected %b", s, bus.CPU_ACK, slot_kind == 2); end
            if (slot_kind == 1) begin
                exp_d = exp_q.pop_front();
                n_cmp++; if (bus.REN_DO !== exp_d) begin n_fail++; $display("FAIL rnd_ren_do slot %0d: got %h expected %h", s, bus.REN_DO, exp_d); end
            end
            if (slot_kind == 2) begin
                if (s_we) mem_ref[s_a] = s_di;
                else begin
                    n_cmp++; if (bus.CPU_DO !== mem_ref[s_a]) begin n_fail++; $display("FAIL rnd_cpu_do slot %0d: got %h expected %h", s, bus.CPU_DO, mem_ref[s_a]); end
                end
            end
            // choose the next slot
            pend = cpu_req && (slot_kind != 2);
            if (slot_kind == 2) cpu_req = 0;
            force_cpu = 0;
`ifdef EPOCHTV1_VRAM_ANTISTARVE_EN
            force_cpu = pend && (starve == 4);
`endif
            if (ren_req && !force_cpu) begin
                slot_kind = 1; exp_q.push_back(mem_ref[ren_a]);
                starve = pend ? starve + 1 : 0;
                e_va = ren_a[10:0]; e_cs = ren_a[11] ? 2'b01 : 2'b10; e_we_n = 1;
            end else if (pend) begin
                slot_kind = 2; s_a = req_a; s_we = req_we; s_di = req_di; starve = 0;
                e_va = req_a[10:0]; e_cs = req_a[11] ? 2'b01 : 2'b10; e_we_n = !req_we;
            end else begin
                slot_kind = 0; starve = 0;
                e_va = 0; e_cs = 2'b11; e_we_n = 1;
            end
            n_cmp++; if (bus.VA !== e_va || bus.nVCS !== e_cs || bus.nVWE !== e_we_n)
                begin n_fail++; $display("FAIL rnd_grant slot %0d: got va=%h cs=%b we_n=%b expected va=%h cs=%b we_n=%b", s, bus.VA, bus.nVCS, bus.nVWE, e_va, e_cs, e_we_n); end
        end
        bus.CPU_REQ = 0; bus.REN_REQ = 0;
        wait_ce_edge(); wait_ce_edge();
        n_cmp++; if (bad_pulse !== 0) begin n_fail++; $display("FAIL rnd_pulse_off_ce: got %0d clocks expected 0", bad_pulse); end
        n_cmp++; if (bad_pins !== 0) begin n_fail++; $display("FAIL rnd_pin_hold: got %0d clocks expected 0", bad_pins); end
    endtask

    initial begin
        test_reset();
        wait_ce_edge();
        test_read();
        test_write();
        test_contention();
        test_starve();
        test_reset_mid();
        test_abandon();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
